nts_ip_decoder: RTL and testbench

Receive-side IPv4/UDP header decoder for the NTS engine. It sits beside the parser controller, watches the 64-bit Ethernet frame stream while it is being copied, and checks the Ethernet/IPv4/UDP headers. After the frame ends it reports IPv4 detection and header validity. The controller can then read decoded values, currently the NTP header location, via a small opcode interface.

---
 rtl/nts_ip_decoder.sv | 176 +++++++++++++++++
 tb/tb_nts_ip_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nts_ip_decoder.sv
// Receive-side Ethernet/IPv4/UDP header decoder: snoops the 64-bit frame stream, validates the
// IPv4 header once the frame ends and serves decoded values through a registered opcode port.
module nts_ip_decoder #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_clear,
    input  logic        i_process,
    input  logic [7:0]  i_last_word_data_valid,
    input  logic [63:0] i_data,
    input  logic [3:0]  i_read_opcode,
    output logic        o_detect_ipv4,
    output logic        o_detect_ipv4_bad,
    output logic [31:0] o_read_data
);

    localparam logic [3:0]  OpGetNtpOffset = 4'h0;
    localparam int unsigned NtpByteOffset  = 42;
    localparam int unsigned CntW           = ADDR_WIDTH + 4;
    localparam logic [31:0] NtpOffsetEnc   = 32'((NtpByteOffset / 8) * 16 + NtpByteOffset % 8);
    localparam logic [ADDR_WIDTH-1:0] WordMax = '1;

    logic                  idle_q, idle_d;
    logic                  active_q, active_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            mask_q, mask_d;
    logic [15:0]           ethertype_q, ethertype_d;
    logic [7:0]            verihl_q, verihl_d;
    logic [15:0]           totlen_q, totlen_d;
    logic [7:0]            proto_q, proto_d;
    logic [19:0]           csum_q, csum_d;
    logic                  ipv4_q, ipv4_d;
    logic                  bad_q, bad_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  frame_start;
    logic [3:0]            pop_cnt;
    logic [CntW-1:0]       byte_cnt;
    logic [16:0]           csum_s1;
    logic [15:0]           csum_fold;
    logic [16:0]           len_need;
    logic [19:0]           word_hsum;

    assign word_hsum = 20'(i_data[63:48]) + 20'(i_data[47:32]) +
                       20'(i_data[31:16]) + 20'(i_data[15:0]);

    always_comb begin
        idle_d      = ~i_process;
        active_d    = active_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        mask_d      = mask_q;
        ethertype_d = ethertype_q;
        verihl_d    = verihl_q;
        totlen_d    = totlen_q;
        proto_d     = proto_q;
        csum_d      = csum_q;
        ipv4_d      = ipv4_q;
        bad_d       = bad_q;

        pop_cnt = '0;
        for (int k = 0; k < 8; k++) begin
            pop_cnt = pop_cnt + 4'(mask_q[k]);
        end
        byte_cnt  = CntW'({idx_q, 3'b000}) + CntW'(pop_cnt);
        // End-around carry fold of the raw halfword sum
        csum_s1   = 17'(csum_q[15:0]) + 17'(csum_q[19:16]);
        csum_fold = csum_s1[15:0] + 16'(csum_s1[16]);
        len_need  = 17'(totlen_q) + 17'd14;

        // idle_q gates starts so a frame cut by reset/clear is ignored until i_process drops
        frame_start = i_process & idle_q;

        if (frame_start) begin
            active_d    = 1'b1;
            idx_d       = '0;
            ovf_d       = 1'b0;
            mask_d      = i_last_word_data_valid;
            ethertype_d = '0;
            verihl_d    = '0;
            totlen_d    = '0;
            proto_d     = '0;
            csum_d      = '0;
            ipv4_d      = 1'b0;
            bad_d       = 1'b0;
        end else if (active_q && i_process) begin
            idx_d  = (idx_q == WordMax) ? WordMax : idx_q + ADDR_WIDTH'(1);
            mask_d = i_last_word_data_valid;
            if (idx_d == WordMax) begin
                ovf_d = 1'b1;
            end
            if (idx_d == ADDR_WIDTH'(1)) begin
                ethertype_d = i_data[31:16];
                verihl_d    = i_data[15:8];
                csum_d      = csum_q + 20'(i_data[15:0]);
            end else if (idx_d == ADDR_WIDTH'(2)) begin
                totlen_d = i_data[63:48];
                proto_d  = i_data[7:0];
                csum_d   = csum_q + word_hsum;
            end else if (idx_d == ADDR_WIDTH'(3)) begin
                csum_d = csum_q + word_hsum;
            end else if (idx_d == ADDR_WIDTH'(4)) begin
                csum_d = csum_q + 20'(i_data[63:48]);
            end
        end else if (active_q) begin
            active_d = 1'b0;
            ipv4_d   = (ethertype_q == 16'h0800) && (verihl_q[7:4] == 4'd4) && (idx_q != '0);
            bad_d    = ipv4_d && ((verihl_q[3:0] != 4'd5) ||
                                  (proto_q != 8'd17) ||
                                  (csum_fold != 16'hFFFF) ||
                                  (32'(len_need) > 32'(byte_cnt)) ||
                                  (byte_cnt < CntW'(NtpByteOffset)) ||
                                  ovf_q);
        end

        // Read path sees the flags as held before this edge
        if ((i_read_opcode == OpGetNtpOffset) && ipv4_q && !bad_q) begin
            rdata_d = NtpOffsetEnc;
        end else begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_areset) begin
        if (!i_areset) begin
            idle_q      <= 1'b0;
            active_q    <= 1'b0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            mask_q      <= '0;
            ethertype_q <= '0;
            verihl_q    <= '0;
            totlen_q    <= '0;
            proto_q     <= '0;
            csum_q      <= '0;
            ipv4_q      <= 1'b0;
            bad_q       <= 1'b0;
            rdata_q     <= '0;
        end else if (i_clear) begin
            idle_q      <= ~i_process;
            active_q    <= 1'b0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            mask_q      <= '0;
            ethertype_q <= '0;
            verihl_q    <= '0;
            totlen_q    <= '0;
            proto_q     <= '0;
            csum_q      <= '0;
            ipv4_q      <= 1'b0;
            bad_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            idle_q      <= idle_d;
            active_q    <= active_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            mask_q      <= mask_d;
            ethertype_q <= ethertype_d;
            verihl_q    <= verihl_d;
            totlen_q    <= totlen_d;
            proto_q     <= proto_d;
            csum_q      <= csum_d;
            ipv4_q      <= ipv4_d;
            bad_q       <= bad_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_detect_ipv4     = ipv4_q;
    assign o_detect_ipv4_bad = bad_q;
    assign o_read_data       = rdata_q;

endmodule

// File: tb/tb_nts_ip_decoder.sv
// Self-checking bench for nts_ip_decoder: directed frames plus randomized, mutated frames
// checked against a byte-level reference model.
module tb_nts_ip_decoder;

    logic        clk = 1'b0;
    logic        areset;
    logic        clear;
    logic        process;
    logic [7:0]  last_valid;
    logic [63:0] data;
    logic [3:0]  opcode;
    logic        det_ipv4;
    logic        det_bad;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] frm [0:255];

    nts_ip_decoder #(
        .ADDR_WIDTH(10)
    ) u_dut (
        .i_clk                 (clk),
        .i_areset              (areset),
        .i_clear               (clear),
        .i_process             (process),
        .i_last_word_data_valid(last_valid),
        .i_data                (data),
        .i_read_opcode         (opcode),
        .o_detect_ipv4         (det_ipv4),
        .o_detect_ipv4_bad     (det_bad),
        .o_read_data           (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void fix_csum();
        int s;
        frm[24] = 8'h00;
        frm[25] = 8'h00;
        s = 0;
        for (int k = 0; k < 10; k++) s += int'({frm[14+2*k], frm[15+2*k]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        s = ~s & 32'hFFFF;
        frm[24] = s[15:8];
        frm[25] = s[7:0];
    endfunction

    function automatic void load_plan_frame();
        logic [159:0] hdr;
        logic [63:0]  udp;
        hdr = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
        udp = 64'h007b_007b_005f_0000;
        for (int i = 0; i < 256; i++) frm[i] = 8'($urandom);
        frm[12] = 8'h08;
        frm[13] = 8'h00;
        for (int i = 0; i < 20; i++) frm[14+i] = hdr[159-8*i -: 8];
        for (int i = 0; i < 8; i++) frm[34+i] = udp[63-8*i -: 8];
    endfunction

    function automatic int build_valid(input int pay_len);
        int tl;
        for (int i = 0; i < 256; i++) frm[i] = 8'($urandom);
        tl = 28 + pay_len;
        frm[12] = 8'h08;
        frm[13] = 8'h00;
        frm[14] = 8'h45;
        frm[16] = tl[15:8];
        frm[17] = tl[7:0];
        frm[23] = 8'd17;
        fix_csum();
        return 42 + pay_len;
    endfunction

    // Reference: decode the bytes actually delivered (bytes past n are sent as zero)
    function automatic void model(input int n, output bit ip, output bit bad);
        logic [7:0] b [0:47];
        int s;
        int tl;
        for (int i = 0; i < 48; i++) b[i] = (i < n) ? frm[i] : 8'h00;
        ip = ({b[12], b[13]} == 16'h0800) && (b[14][7:4] == 4'h4) && (((n + 7) / 8) >= 2);
        s = 0;
        for (int k = 0; k < 10; k++) s += int'({b[14+2*k], b[15+2*k]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        tl = int'({b[16], b[17]});
        bad = ip && ((b[14][3:0] != 4'h5) || (b[23] != 8'd17) || (s != 32'hFFFF) ||
                     (14 + tl > n) || (n < 42));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] opc, input bit ip, input bit bad);
        return (opc == 4'h0 && ip && !bad) ? 32'h0000_0052 : 32'h0;
    endfunction

    task automatic drive_word(input int w, input int n);
        @(negedge clk);
        process = 1'b1;
        for (int k = 0; k < 8; k++) begin
            data[63-8*k -: 8] = (w * 8 + k < n) ? frm[w*8+k] : 8'h00;
            last_valid[7-k]   = (w * 8 + k < n);
        end
    endtask

    task automatic send_frame(input int n);
        for (int w = 0; w < (n + 7) / 8; w++) drive_word(w, n);
        @(negedge clk);
        process = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int n, input logic [3:0] opc,
                             input bit eip, input bit ebad, input logic [31:0] erd);
        opcode = opc;
        send_frame(n);
        @(negedge clk);
        check({tag, "_ipv4"}, 32'(det_ipv4), 32'(eip));
        check({tag, "_bad"}, 32'(det_bad), 32'(ebad));
        check({tag, "_rd_lat"}, rdata, 32'h0);
        @(negedge clk);
        check({tag, "_rd"}, rdata, erd);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ipv4"}, 32'(det_ipv4), 32'h0);
        check({tag, "_bad"}, 32'(det_bad), 32'h0);
        check({tag, "_rd"}, rdata, 32'h0);
    endtask

    int          n;
    bit          m_ip;
    bit          m_bad;
    logic [3:0]  opc;
    logic [7:0]  tmp;

    initial begin
        areset     = 1'b0;
        clear      = 1'b0;
        process    = 1'b0;
        last_valid = 8'h00;
        data       = 64'h0;
        opcode     = 4'h0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);

        load_plan_frame();
        run_frame("valid", 129, 4'h0, 1'b1, 1'b0, 32'h52);
        frm[25] = 8'h62;
        run_frame("csum", 129, 4'h0, 1'b1, 1'b1, 32'h0);
        load_plan_frame();
        frm[23] = 8'h06;
        fix_csum();
        run_frame("proto", 129, 4'h0, 1'b1, 1'b1, 32'h0);
        load_plan_frame();
        run_frame("trunc", 120, 4'h0, 1'b1, 1'b1, 32'h0);
        load_plan_frame();
        frm[12] = 8'h86;
        frm[13] = 8'hDD;
        run_frame("v6", 129, 4'h0, 1'b0, 1'b0, 32'h0);
        load_plan_frame();
        run_frame("oneword", 8, 4'h0, 1'b0, 1'b0, 32'h0);
        run_frame("op3", 129, 4'h3, 1'b1, 1'b0, 32'h0);

        // Async reset while idle with flags set: outputs drop without a clock edge
        run_frame("pre_rst", 129, 4'h0, 1'b1, 1'b0, 32'h52);
        @(negedge clk);
        #2 areset = 1'b0;
        #1 check_zero("rst_async");
        @(negedge clk);
        areset = 1'b1;

        // Reset mid-frame, then a full valid frame with i_process never dropping: must be ignored
        for (int w = 0; w < 3; w++) drive_word(w, 129);
        #2 areset = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk);
        areset = 1'b1;
        send_frame(129);
        repeat (2) @(negedge clk);
        check_zero("rst_abort");
        run_frame("post_rst", 129, 4'h0, 1'b1, 1'b0, 32'h52);

        // Synchronous clear after a valid frame
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero("clear");

        // Clear mid-frame aborts the rest of the frame
        for (int w = 0; w < 3; w++) drive_word(w, 129);
        clear = 1'b1;
        drive_word(3, 129);
        clear = 1'b0;
        for (int w = 4; w < 17; w++) drive_word(w, 129);
        @(negedge clk);
        process = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("clr_abort");
        run_frame("post_clr", 129, 4'h0, 1'b1, 1'b0, 32'h52);

        for (int t = 0; t < 60; t++) begin
            n = build_valid(int'($urandom_range(0, 150)));
            case ($urandom_range(0, 8))
                1: begin frm[12] = 8'($urandom); frm[13] = 8'($urandom); end
                2: begin tmp = frm[14]; tmp[7:4] = 4'($urandom); frm[14] = tmp; fix_csum(); end
                3: begin tmp = frm[14]; tmp[3:0] = 4'($urandom); frm[14] = tmp; fix_csum(); end
                4: begin frm[23] = 8'($urandom); fix_csum(); end
                5: frm[24] = frm[24] ^ (8'h01 << $urandom_range(0, 7));
                6: n = int'($urandom_range(1, n - 1));
                7: begin frm[17] = frm[17] + 8'($urandom_range(1, 20)); fix_csum(); end
                default: ;
            endcase
            opc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            model(n, m_ip, m_bad);
            run_frame($sformatf("rand%0d", t), n, opc, m_ip, m_bad, exp_rd(opc, m_ip, m_bad));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
